// File: rtl/md_unit.sv
// Multiply/divide unit for the E stage: fixed-latency MULT/MULTU/DIV/DIVU plus the HI/LO registers.
// The result is formed combinationally from latched operands and only reaches HI/LO on the final busy edge.
module md_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  md_op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);
    localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES);
    localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t           state, next_state;
    logic [CNT_W-1:0] cnt;
    logic [1:0]       op_q;
    logic [31:0]      a_q, b_q;
    logic             launch, commit, write_hi, write_lo;

    logic [63:0] prod_s, prod_u;
    logic [31:0] a_mag, b_mag, div_num, div_den, den_safe;
    logic [31:0] q_u, r_u, quot, rem;
    logic [31:0] res_hi, res_lo;
    logic        is_signed, div_by_zero;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= next_state;
            if (launch)
                cnt <= md_op[1] ? DIV_LOAD : MULT_LOAD;
            else if (state == RUN)
                cnt <= cnt - CNT_ONE;
        end
    end

    always_comb begin
        next_state = state;
        launch     = 1'b0;
        commit     = 1'b0;
        write_hi   = 1'b0;
        write_lo   = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    case (md_op)
                        3'd0, 3'd1, 3'd2, 3'd3: begin
                            launch     = 1'b1;
                            next_state = RUN;
                        end
                        3'd4:    write_hi = 1'b1;
                        3'd5:    write_lo = 1'b1;
                        default: ;
                    endcase
                end
            end
            RUN: begin
                if (cnt == CNT_ONE) begin
                    commit     = 1'b1;
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Signed divide runs on magnitudes; 0x80000000 keeps its own magnitude, which yields the overflow result naturally.
    always_comb begin
        is_signed = ~op_q[0];
        prod_s    = {{32{a_q[31]}}, a_q} * {{32{b_q[31]}}, b_q};
        prod_u    = {32'h0, a_q} * {32'h0, b_q};
        a_mag     = a_q[31] ? (32'h0 - a_q) : a_q;
        b_mag     = b_q[31] ? (32'h0 - b_q) : b_q;
        div_num   = is_signed ? a_mag : a_q;
        div_den   = is_signed ? b_mag : b_q;
        den_safe  = (div_den == 32'h0) ? 32'h1 : div_den;
        q_u       = div_num / den_safe;
        r_u       = div_num % den_safe;
        quot      = q_u;
        rem       = r_u;
        if (is_signed) begin
            quot = (a_q[31] ^ b_q[31]) ? (32'h0 - q_u) : q_u;
            rem  = a_q[31] ? (32'h0 - r_u) : r_u;
        end
        div_by_zero = op_q[1] && (b_q == 32'h0);
        case (op_q)
            2'd0:    {res_hi, res_lo} = prod_s;
            2'd1:    {res_hi, res_lo} = prod_u;
            default: {res_hi, res_lo} = {rem, quot};
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            op_q <= '0;
            a_q  <= '0;
            b_q  <= '0;
            hi   <= '0;
            lo   <= '0;
        end else begin
            if (launch) begin
                op_q <= md_op[1:0];
                a_q  <= a;
                b_q  <= b;
            end
            if (commit && !div_by_zero) begin
                hi <= res_hi;
                lo <= res_lo;
            end
            if (write_hi)
                hi <= a;
            if (write_lo)
                lo <= a;
        end
    end

    assign busy = (state == RUN);

endmodule
